// File: rtl/ili9341_window_spi_controller.sv
// ILI9341 controller: power-up/init, status readback, then windowed pixel streaming
// from the frame-buffer memory controller to the SPI master.
module ili9341_window_spi_controller #(
    parameter int         SYS_CLK_FREQ = 12000000,
    parameter int         DISPLAY_X    = 320,
    parameter int         DISPLAY_Y    = 240,
    parameter logic [7:0] MADCTL_VAL   = 8'h28,
    parameter int         PIXEL_BITS   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_busy,
    input  logic [7:0]  spi_in,
    input  logic [7:0]  mem_in,
    input  logic        mem_ready,
    input  logic        win_valid,
    input  logic [15:0] win_x0,
    input  logic [15:0] win_x1,
    input  logic [15:0] win_y0,
    input  logic [15:0] win_y1,
    input  logic [31:0] win_base,
    output logic        win_ready,
    output logic        win_err,
    output logic        frame_done,
    output logic        dis_reset,
    output logic        dc,
    output logic        spi_start,
    output logic [7:0]  spi_out,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    output logic [31:0] display_status
);
    localparam int HOLD = (SYS_CLK_FREQ / 100000 > 4) ? SYS_CLK_FREQ / 100000 : 4;
    localparam int REL  = (SYS_CLK_FREQ / 200 > 4) ? SYS_CLK_FREQ / 200 : 4;
    localparam int SWR  = (SYS_CLK_FREQ / 200 > 4) ? SYS_CLK_FREQ / 200 : 4;
    localparam int SLP  = (SYS_CLK_FREQ / 8 > 4) ? SYS_CLK_FREQ / 8 : 4;
    localparam logic [31:0] HOLD_C = 32'(HOLD - 1);
    localparam logic [31:0] REL_C  = 32'(REL);
    localparam logic [31:0] SWR_C  = 32'(SWR);
    localparam logic [31:0] SLP_C  = 32'(SLP);
    localparam logic [31:0] DX_C   = 32'(DISPLAY_X);
    localparam logic [31:0] DY_C   = 32'(DISPLAY_Y);
    localparam logic [31:0] BPP    = (PIXEL_BITS == 18) ? 32'd3 : 32'd2;
    localparam logic [7:0]  COLMOD = (PIXEL_BITS == 18) ? 8'h66 : 8'h55;

    typedef enum logic [3:0] {
        S_HOLD, S_REL, S_INIT, S_DELAY, S_IDLE, S_HDR,
        S_MREQ, S_MWAIT, S_GO, S_GAP, S_WAIT
    } state_t;
    typedef enum logic [1:0] {M_INIT, M_HDR, M_PIX} mode_t;

    state_t      state_q, state_d;
    mode_t       mode_q, mode_d;
    logic [3:0]  step_q, step_d;
    logic [31:0] cnt_q, cnt_d, idx_q, idx_d, total_q, total_d, base_q, base_d;
    logic [15:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [7:0]  byte_q, byte_d;
    logic        dc_q, dc_d, spi_start_q, spi_start_d, mem_req_q, mem_req_d;
    logic        dis_reset_q, dis_reset_d, win_ready_q, win_ready_d;
    logic        win_err_q, win_err_d, frame_done_q, frame_done_d;
    logic [31:0] mem_addr_q, mem_addr_d, status_q, status_d;
    logic [31:0] width, height;
    logic        win_ok;

    // Init script: {dc, byte}; steps 8..12 are the RDDST dummy reads.
    function automatic logic [8:0] init_byte(input logic [3:0] s);
        case (s)
            4'd0:    init_byte = {1'b0, 8'h01};
            4'd1:    init_byte = {1'b0, 8'h11};
            4'd2:    init_byte = {1'b0, 8'h36};
            4'd3:    init_byte = {1'b1, MADCTL_VAL};
            4'd4:    init_byte = {1'b0, 8'h3A};
            4'd5:    init_byte = {1'b1, COLMOD};
            4'd6:    init_byte = {1'b0, 8'h29};
            4'd7:    init_byte = {1'b0, 8'h09};
            default: init_byte = {1'b1, 8'h00};
        endcase
    endfunction

    function automatic logic [8:0] hdr_byte(input logic [3:0] s, input logic [15:0] a0,
                                            input logic [15:0] a1, input logic [15:0] b0,
                                            input logic [15:0] b1);
        case (s)
            4'd0:    hdr_byte = {1'b0, 8'h2A};
            4'd1:    hdr_byte = {1'b1, a0[15:8]};
            4'd2:    hdr_byte = {1'b1, a0[7:0]};
            4'd3:    hdr_byte = {1'b1, a1[15:8]};
            4'd4:    hdr_byte = {1'b1, a1[7:0]};
            4'd5:    hdr_byte = {1'b0, 8'h2B};
            4'd6:    hdr_byte = {1'b1, b0[15:8]};
            4'd7:    hdr_byte = {1'b1, b0[7:0]};
            4'd8:    hdr_byte = {1'b1, b1[15:8]};
            4'd9:    hdr_byte = {1'b1, b1[7:0]};
            default: hdr_byte = {1'b0, 8'h2C};
        endcase
    endfunction

    assign width  = {16'd0, win_x1 - win_x0} + 32'd1;
    assign height = {16'd0, win_y1 - win_y0} + 32'd1;
    assign win_ok = (win_x0 <= win_x1) && ({16'd0, win_x1} < DX_C) &&
                    (win_y0 <= win_y1) && ({16'd0, win_y1} < DY_C);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        step_d       = step_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        total_d      = total_q;
        base_d       = base_q;
        x0_d         = x0_q;
        x1_d         = x1_q;
        y0_d         = y0_q;
        y1_d         = y1_q;
        byte_d       = byte_q;
        dc_d         = dc_q;
        dis_reset_d  = dis_reset_q;
        mem_addr_d   = mem_addr_q;
        status_d     = status_q;
        spi_start_d  = 1'b0;
        mem_req_d    = 1'b0;
        win_err_d    = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            S_HOLD: begin
                dis_reset_d = 1'b0;
                cnt_d       = cnt_q + 32'd1;
                if (cnt_q == HOLD_C) begin
                    state_d = S_REL;
                    cnt_d   = '0;
                end
            end
            S_REL: begin
                dis_reset_d = 1'b1;
                cnt_d       = cnt_q + 32'd1;
                if (cnt_q == REL_C) begin
                    state_d = S_INIT;
                    mode_d  = M_INIT;
                    step_d  = '0;
                end
            end
            S_INIT: begin
                {dc_d, byte_d} = init_byte(step_q);
                state_d        = S_GO;
            end
            S_DELAY: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == ((step_q == 4'd0) ? SWR_C : SLP_C)) begin
                    step_d  = step_q + 4'd1;
                    state_d = S_INIT;
                end
            end
            S_IDLE: begin
                if (win_valid) begin
                    if (win_ok) begin
                        x0_d    = win_x0;
                        x1_d    = win_x1;
                        y0_d    = win_y0;
                        y1_d    = win_y1;
                        base_d  = win_base;
                        total_d = width * height * BPP;
                        mode_d  = M_HDR;
                        step_d  = '0;
                        state_d = S_HDR;
                    end else begin
                        win_err_d = 1'b1;
                    end
                end
            end
            S_HDR: begin
                {dc_d, byte_d} = hdr_byte(step_q, x0_q, x1_q, y0_q, y1_q);
                state_d        = S_GO;
            end
            S_MREQ: begin
                mem_addr_d = base_q + idx_q;
                mem_req_d  = 1'b1;
                state_d    = S_MWAIT;
            end
            S_MWAIT: begin
                if (mem_ready) begin
                    byte_d  = mem_in;
                    dc_d    = 1'b1;
                    state_d = S_GO;
                end
            end
            S_GO: begin
                if (!spi_busy) begin
                    spi_start_d = 1'b1;
                    state_d     = S_GAP;
                end
            end
            // The master may not have raised busy yet in the cycle after the pulse.
            S_GAP: state_d = S_WAIT;
            S_WAIT: begin
                if (!spi_busy) begin
                    case (mode_q)
                        M_INIT: begin
                            if (step_q >= 4'd9) status_d = {status_q[23:0], spi_in};
                            if (step_q <= 4'd1) begin
                                cnt_d   = '0;
                                state_d = S_DELAY;
                            end else if (step_q == 4'd12) begin
                                state_d = S_IDLE;
                            end else begin
                                step_d  = step_q + 4'd1;
                                state_d = S_INIT;
                            end
                        end
                        M_HDR: begin
                            if (step_q == 4'd10) begin
                                mode_d  = M_PIX;
                                idx_d   = '0;
                                state_d = S_MREQ;
                            end else begin
                                step_d  = step_q + 4'd1;
                                state_d = S_HDR;
                            end
                        end
                        default: begin
                            if (idx_q == total_q - 32'd1) begin
                                frame_done_d = 1'b1;
                                state_d      = S_IDLE;
                            end else begin
                                idx_d   = idx_q + 32'd1;
                                state_d = S_MREQ;
                            end
                        end
                    endcase
                end
            end
            default: state_d = S_HOLD;
        endcase
        win_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_HOLD;
            mode_q       <= M_INIT;
            step_q       <= '0;
            cnt_q        <= '0;
            byte_q       <= '0;
            dc_q         <= 1'b0;
            spi_start_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            dis_reset_q  <= 1'b1;
            win_ready_q  <= 1'b0;
            win_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            mem_addr_q   <= '0;
            status_q     <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            byte_q       <= byte_d;
            dc_q         <= dc_d;
            spi_start_q  <= spi_start_d;
            mem_req_q    <= mem_req_d;
            dis_reset_q  <= dis_reset_d;
            win_ready_q  <= win_ready_d;
            win_err_q    <= win_err_d;
            frame_done_q <= frame_done_d;
            mem_addr_q   <= mem_addr_d;
            status_q     <= status_d;
        end
        idx_q   <= idx_d;
        total_q <= total_d;
        base_q  <= base_d;
        x0_q    <= x0_d;
        x1_q    <= x1_d;
        y0_q    <= y0_d;
        y1_q    <= y1_d;
    end

    assign win_ready      = win_ready_q;
    assign win_err        = win_err_q;
    assign frame_done     = frame_done_q;
    assign dis_reset      = dis_reset_q;
    assign dc             = dc_q;
    assign spi_start      = spi_start_q;
    assign spi_out        = byte_q;
    assign mem_addr       = mem_addr_q;
    assign mem_req        = mem_req_q;
    assign display_status = status_q;
endmodule

// File: tb/tb_ili9341_window_spi_controller.sv
// Bench for ili9341_window_spi_controller: RGB565 and RGB666 instances with SPI/memory mocks
// and a byte scoreboard on the selected instance.
module tb_ili9341_window_spi_controller;
    logic clk = 1'b0;
    logic reset;
    logic [1:0] spi_busy, mem_ready, win_valid, win_ready, win_err, frame_done;
    logic [1:0] dis_reset, dc, spi_start, mem_req;
    logic [1:0][7:0] spi_in, mem_in, spi_out;
    logic [1:0][31:0] mem_addr, display_status;
    logic [15:0] wx0, wx1, wy0, wy1;
    logic [31:0] wbase;
    int sel = 0;
    logic rx_mode = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ncap = 0;
    int fd_cnt[2] = '{0, 0};
    int err_cnt[2] = '{0, 0};
    logic [8:0] exp_q[$];
    int start_cyc[$];
    logic [8:0] exp_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] memf(input logic [31:0] a);
        return ((a[7:0] * 8'd7) ^ a[15:8]) + 8'h13;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [2:0] bcnt = '0;
        logic [7:0] xfer = '0;
        logic       mrdy = 1'b0;
        logic [7:0] mdat = '0;

        ili9341_window_spi_controller #(
            .SYS_CLK_FREQ(1), .DISPLAY_X(3), .DISPLAY_Y(4),
            .MADCTL_VAL(8'h28), .PIXEL_BITS((g == 0) ? 16 : 18)
        ) u_dut (
            .clk(clk), .reset(reset), .spi_busy(spi_busy[g]), .spi_in(spi_in[g]),
            .mem_in(mem_in[g]), .mem_ready(mem_ready[g]), .win_valid(win_valid[g]),
            .win_x0(wx0), .win_x1(wx1), .win_y0(wy0), .win_y1(wy1), .win_base(wbase),
            .win_ready(win_ready[g]), .win_err(win_err[g]), .frame_done(frame_done[g]),
            .dis_reset(dis_reset[g]), .dc(dc[g]), .spi_start(spi_start[g]),
            .spi_out(spi_out[g]), .mem_addr(mem_addr[g]), .mem_req(mem_req[g]),
            .display_status(display_status[g])
        );

        // SPI master mock: busy for 4 cycles after each start; rx byte = transfer number.
        always @(posedge clk) begin
            if (spi_start[g]) bcnt <= 3'd4;
            else if (bcnt != 3'd0) bcnt <= bcnt - 3'd1;
            if (reset) xfer <= 8'd0;
            else if (spi_start[g]) xfer <= xfer + 8'd1;
            mrdy <= mem_req[g];
            mdat <= memf(mem_addr[g]);
        end
        assign spi_busy[g]  = (bcnt != 3'd0);
        assign spi_in[g]    = rx_mode ? xfer : 8'hAA;
        assign mem_ready[g] = mrdy;
        assign mem_in[g]    = mdat;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every spi_start on the watched instance pops one expected {dc, byte}.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (frame_done[g]) fd_cnt[g]++;
            if (win_err[g]) err_cnt[g]++;
        end
        if (spi_start[sel]) begin
            ncap++;
            start_cyc.push_back(cyc);
            if (exp_q.size() != 0) exp_e = exp_q.pop_front();
            else exp_e = 9'bx;
            chk("spi_byte", {55'd0, dc[sel], spi_out[sel]}, {55'd0, exp_e});
        end
    end

    task automatic push_init(input logic [7:0] colmod);
        exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h36}); exp_q.push_back({1'b1, 8'h28});
        exp_q.push_back({1'b0, 8'h3A}); exp_q.push_back({1'b1, colmod});
        exp_q.push_back({1'b0, 8'h29}); exp_q.push_back({1'b0, 8'h09});
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, 8'h00});
    endtask

    task automatic push_hdr(input logic [15:0] x0, input logic [15:0] x1,
                            input logic [15:0] y0, input logic [15:0] y1);
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, x0[15:8]}); exp_q.push_back({1'b1, x0[7:0]});
        exp_q.push_back({1'b1, x1[15:8]}); exp_q.push_back({1'b1, x1[7:0]});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, y0[15:8]}); exp_q.push_back({1'b1, y0[7:0]});
        exp_q.push_back({1'b1, y1[15:8]}); exp_q.push_back({1'b1, y1[7:0]});
        exp_q.push_back({1'b0, 8'h2C});
    endtask

    task automatic chk_reset(input int g);
        chk("reset_ctrl", {57'd0, dis_reset[g], spi_start[g], win_ready[g], mem_req[g],
            frame_done[g], win_err[g], dc[g]}, 64'b1000000);
        chk("reset_spi_out", {56'd0, spi_out[g]}, 64'd0);
        chk("reset_mem_addr", {32'd0, mem_addr[g]}, 64'd0);
        chk("reset_status", {32'd0, display_status[g]}, 64'd0);
    endtask

    task automatic check_init();
        int n = 0;
        int low = 0;
        int rise;
        int s0, s1;
        while (dis_reset[sel] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        while (dis_reset[sel] === 1'b0 && n < 200) begin @(negedge clk); n++; low++; end
        rise = cyc;
        chk("dis_reset_low_cycles", low, 4);
        n = 0;
        while (start_cyc.size() < 2 && n < 400) begin @(negedge clk); n++; end
        chk("init_starts_seen", start_cyc.size() >= 2, 1);
        s0 = (start_cyc.size() >= 1) ? start_cyc[0] : rise;
        s1 = (start_cyc.size() >= 2) ? start_cyc[1] : s0;
        chk("swreset_after_rel", (s0 - rise) > 4, 1);
        chk("sleepout_after_swr", (s1 - s0) > 9, 1);
    endtask

    task automatic wait_idle(input logic [31:0] status);
        int n = 0;
        while (win_ready[sel] !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        chk("win_ready_after_init", win_ready[sel], 1);
        chk("init_bytes_drained", exp_q.size(), 0);
        chk("display_status", display_status[sel], status);
    endtask

    task automatic send_win(input int g, input logic [15:0] x0, input logic [15:0] x1,
                            input logic [15:0] y0, input logic [15:0] y1, input logic [31:0] b);
        wx0 = x0; wx1 = x1; wy0 = y0; wy1 = y1; wbase = b;
        win_valid[g] = 1'b1;
        @(negedge clk);
        win_valid[g] = 1'b0;
    endtask

    task automatic wait_fd(input int target);
        int n = 0;
        while (fd_cnt[sel] < target && n < 3000) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        chk("frame_done_count", fd_cnt[sel], target);
        chk("frame_bytes_drained", exp_q.size(), 0);
        chk("win_ready_after_frame", win_ready[sel], 1);
    endtask

    initial begin
        logic [15:0] ex0[3] = '{16'd0, 16'd2, 16'd0};
        logic [15:0] ex1[3] = '{16'd3, 16'd1, 16'd0};
        logic [15:0] ey1[3] = '{16'd0, 16'd0, 16'd4};
        int e0, fd1, n0, n;
        logic drop;
        reset = 1'b1; win_valid = 2'b00;
        wx0 = '0; wx1 = '0; wy0 = '0; wy1 = '0; wbase = '0;

        // Init on the RGB565 instance with a constant 0xAA status reply
        repeat (3) @(negedge clk);
        chk_reset(0);
        push_init(8'h55);
        reset = 1'b0;
        check_init();
        wait_idle(32'hAAAAAAAA);

        // Full-screen window (0,0)-(2,3): 24 bytes
        push_hdr(16'd0, 16'd2, 16'd0, 16'd3);
        for (int i = 0; i < 24; i++) exp_q.push_back({1'b1, memf(32'(i))});
        send_win(0, 16'd0, 16'd2, 16'd0, 16'd3, 32'd0);
        wait_fd(1);
        chk("mem_addr_holds_last", mem_addr[0], 32'd23);

        // Rejected windows: no traffic, win_ready stays high
        for (int k = 0; k < 3; k++) begin
            e0 = err_cnt[0];
            drop = 1'b0;
            wx0 = ex0[k]; wx1 = ex1[k]; wy0 = 16'd0; wy1 = ey1[k];
            win_valid[0] = 1'b1;
            @(negedge clk);
            if (win_ready[0] !== 1'b1) drop = 1'b1;
            win_valid[0] = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (win_ready[0] !== 1'b1) drop = 1'b1;
            end
            chk("win_err_pulse", err_cnt[0] - e0, 1);
            chk("win_ready_kept_on_err", drop, 0);
        end
        chk("no_frame_on_err", fd_cnt[0], 1);

        // RGB666 instance, status reply = transfer number
        sel = 1; rx_mode = 1'b1;
        reset = 1'b1;
        start_cyc.delete();
        repeat (2) @(negedge clk);
        chk_reset(1);
        push_init(8'h66);
        reset = 1'b0;
        check_init();
        wait_idle(32'h0A0B0C0D);

        // Single pixel (1,2) at base 0x40: 3 bytes
        push_hdr(16'd1, 16'd1, 16'd2, 16'd2);
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, memf(32'h40 + 32'(i))});
        send_win(1, 16'd1, 16'd1, 16'd2, 16'd2, 32'h40);
        wait_fd(1);
        chk("mem_addr_rgb666_last", mem_addr[1], 32'h42);

        // Reset in the middle of a 36-byte stream
        fd1 = fd_cnt[1];
        push_hdr(16'd0, 16'd2, 16'd0, 16'd3);
        for (int i = 0; i < 36; i++) exp_q.push_back({1'b1, memf(32'h100 + 32'(i))});
        n0 = ncap;
        send_win(1, 16'd0, 16'd2, 16'd0, 16'd3, 32'h100);
        n = 0;
        while (ncap < n0 + 20 && n < 2000) begin @(negedge clk); n++; end
        chk("stream_reached_mid", ncap >= n0 + 20, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_reset(1);
        exp_q.delete();
        start_cyc.delete();
        push_init(8'h66);
        @(negedge clk);
        reset = 1'b0;
        check_init();
        wait_idle(32'h0A0B0C0D);
        chk("no_frame_done_after_abort", fd_cnt[1], fd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
